// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between the I-cache refill side and the
// D-side load-store path: pick owner, issue request, count read beats, complete.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_i_req,
    input  logic [ADDR_WIDTH-1:0] i_i_addr,
    output logic                  o_i_grant,
    output logic                  o_i_rdata_valid,
    output logic [DATA_WIDTH-1:0] o_i_rdata,
    output logic                  o_i_done,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH-1:0] i_d_wdata,
    output logic                  o_d_grant,
    output logic                  o_d_rdata_valid,
    output logic [DATA_WIDTH-1:0] o_d_rdata,
    output logic                  o_d_done,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [WW-1:0]         wait_cnt_q, wait_cnt_d;

    logic d_live;
    logic d_flush;
    logic fwd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        beat_cnt_d      = beat_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        o_i_grant       = 1'b0;
        o_i_rdata_valid = 1'b0;
        o_i_rdata       = '0;
        o_i_done        = 1'b0;
        o_d_grant       = 1'b0;
        o_d_rdata_valid = 1'b0;
        o_d_rdata       = '0;
        o_d_done        = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_addr      = '0;
        o_mem_we        = 1'b0;
        o_mem_wdata     = '0;
        d_live          = i_d_req && !i_flush;
        d_flush         = (owner_q == OWN_D) && i_flush;
        fwd             = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_i_req && (wait_cnt_q == WAIT_MAX || !d_live)) begin
                    owner_d = OWN_I;
                    addr_d  = i_i_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ISSUE;
                end else if (d_live) begin
                    owner_d = OWN_D;
                    addr_d  = i_d_addr;
                    we_d    = i_d_we;
                    wdata_d = i_d_we ? i_d_wdata : '0;
                    state_d = ISSUE;
                    if (i_i_req) wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                // A flushed D request is withdrawn unless memory takes it this very cycle.
                if (d_flush && !i_mem_req_ready) begin
                    state_d = IDLE;
                end else begin
                    o_mem_req_valid = 1'b1;
                    o_mem_addr      = addr_q;
                    o_mem_we        = we_q;
                    o_mem_wdata     = wdata_q;
                    if (i_mem_req_ready) begin
                        beat_cnt_d = '0;
                        if (owner_q == OWN_I) begin
                            o_i_grant  = 1'b1;
                            wait_cnt_d = '0;
                            state_d    = BURST;
                        end else begin
                            o_d_grant = 1'b1;
                            if (we_q) begin
                                o_d_done = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                state_d = i_flush ? DRAIN : BURST;
                            end
                        end
                    end
                end
            end
            BURST, DRAIN: begin
                fwd = (state_q == BURST) && !d_flush;
                if (state_q == BURST && d_flush) state_d = DRAIN;
                if (i_mem_rdata_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) state_d = IDLE;
                    if (fwd && owner_q == OWN_I) begin
                        o_i_rdata_valid = 1'b1;
                        o_i_rdata       = i_mem_rdata;
                        o_i_done        = (beat_cnt_q == LAST_BEAT);
                    end else if (fwd) begin
                        o_d_rdata_valid = 1'b1;
                        o_d_rdata       = i_mem_rdata;
                        o_d_done        = (beat_cnt_q == LAST_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Checks mem_port_arbiter against a transaction-level model: directed scenarios
// with literal expectations, then randomized requesters, flushes and memory timing.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int MW = 8;

    logic          clk, rst_n, i_flush;
    logic          i_i_req, o_i_grant, o_i_rdata_valid, o_i_done;
    logic [AW-1:0] i_i_addr;
    logic [DW-1:0] o_i_rdata;
    logic          i_d_req, i_d_we, o_d_grant, o_d_rdata_valid, o_d_done;
    logic [AW-1:0] i_d_addr;
    logic [DW-1:0] i_d_wdata, o_d_rdata;
    logic          o_mem_req_valid, i_mem_req_ready, o_mem_we, i_mem_rdata_valid;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata, i_mem_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_i_req(i_i_req), .i_i_addr(i_i_addr), .o_i_grant(o_i_grant),
        .o_i_rdata_valid(o_i_rdata_valid), .o_i_rdata(o_i_rdata), .o_i_done(o_i_done),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_grant(o_d_grant), .o_d_rdata_valid(o_d_rdata_valid), .o_d_rdata(o_d_rdata),
        .o_d_done(o_d_done), .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata_valid(i_mem_rdata_valid), .i_mem_rdata(i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 = free, 1 = request offered, 2 = beats delivered, 3 = beats discarded.
    int          m_phase, m_left, m_wait;
    bit          m_own_d, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    logic          e_valid, e_we, e_ig, e_iv, e_id, e_dg, e_dv, e_dd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_ir, e_dr;

    logic          s_valid, s_we, s_ig, s_iv, s_id, s_dg, s_dv, s_dd;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_ir, s_dr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_out();
        {e_valid, e_we, e_ig, e_iv, e_id, e_dg, e_dv, e_dd} = '0;
        e_addr = '0; e_wdata = '0; e_ir = '0; e_dr = '0;
        if (m_phase == 1 && !(m_own_d && i_flush && !i_mem_req_ready)) begin
            e_valid = 1'b1;
            e_addr  = m_addr;
            e_we    = m_we;
            e_wdata = m_we ? m_wdata : '0;
            if (i_mem_req_ready) begin
                if (m_own_d) begin e_dg = 1'b1; e_dd = m_we; end
                else e_ig = 1'b1;
            end
        end
        if (m_phase == 2 && i_mem_rdata_valid && !(m_own_d && i_flush)) begin
            if (m_own_d) begin e_dv = 1'b1; e_dr = i_mem_rdata; e_dd = (m_left == 1); end
            else begin e_iv = 1'b1; e_ir = i_mem_rdata; e_id = (m_left == 1); end
        end
    endtask

    task automatic model_next();
        bit d_ok;
        if (!rst_n) begin
            m_phase = 0; m_wait = 0; m_left = 0;
            return;
        end
        case (m_phase)
            0: begin
                d_ok = i_d_req && !i_flush;
                if (i_i_req && (m_wait == MW || !d_ok)) begin
                    m_own_d = 0; m_we = 0; m_addr = i_i_addr; m_phase = 1;
                end else if (d_ok) begin
                    m_own_d = 1; m_we = i_d_we; m_addr = i_d_addr; m_wdata = i_d_wdata; m_phase = 1;
                    if (i_i_req && m_wait < MW) m_wait++;
                end
            end
            1: begin
                if (e_valid && i_mem_req_ready) begin
                    if (!m_own_d) m_wait = 0;
                    if (m_own_d && m_we) m_phase = 0;
                    else begin
                        m_left = BL;
                        m_phase = (m_own_d && i_flush) ? 3 : 2;
                    end
                end else if (!e_valid) m_phase = 0;
            end
            default: begin
                if (m_phase == 2 && m_own_d && i_flush) m_phase = 3;
                if (i_mem_rdata_valid) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            end
        endcase
    endtask

    // One clock: inputs already driven; compare mid-cycle, then advance the model.
    task automatic step();
        #3;
        model_out();
        chk("mem_req_valid", o_mem_req_valid, e_valid);
        chk("mem_addr", o_mem_addr, e_addr);
        chk("mem_we", o_mem_we, e_we);
        chk("mem_wdata", o_mem_wdata, e_wdata);
        chk("i_grant", o_i_grant, e_ig);
        chk("i_rdata_valid", o_i_rdata_valid, e_iv);
        chk("i_rdata", o_i_rdata, e_ir);
        chk("i_done", o_i_done, e_id);
        chk("d_grant", o_d_grant, e_dg);
        chk("d_rdata_valid", o_d_rdata_valid, e_dv);
        chk("d_rdata", o_d_rdata, e_dr);
        chk("d_done", o_d_done, e_dd);
        {s_valid, s_we, s_ig, s_iv, s_id, s_dg, s_dv, s_dd} =
            {o_mem_req_valid, o_mem_we, o_i_grant, o_i_rdata_valid, o_i_done, o_d_grant, o_d_rdata_valid, o_d_done};
        s_addr = o_mem_addr; s_wdata = o_mem_wdata; s_ir = o_i_rdata; s_dr = o_d_rdata;
        @(posedge clk);
        model_next();
        #1;
    endtask

    task automatic beats(input logic [DW-1:0] base);
        for (int k = 0; k < BL; k++) begin
            i_mem_rdata_valid = 1'b1;
            i_mem_rdata = base + DW'(k);
            step();
        end
        i_mem_rdata_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int nd;
        bit got;
        rst_n = 0; i_flush = 0; i_i_req = 0; i_i_addr = '0;
        i_d_req = 0; i_d_we = 0; i_d_addr = '0; i_d_wdata = '0;
        i_mem_req_ready = 0; i_mem_rdata_valid = 0; i_mem_rdata = '0;
        m_phase = 0; m_wait = 0; m_left = 0; m_own_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_mem_valid", s_valid, 0);
        chk("reset_i_grant", s_ig, 0);
        chk("reset_d_done", s_dd, 0);
        rst_n = 1;

        // I-only read, memory always ready
        i_i_req = 1; i_i_addr = 32'h40; i_mem_req_ready = 1;
        step();
        chk("t1_cycle0_valid", s_valid, 0);
        step();
        chk("t1_cycle1_valid", s_valid, 1);
        chk("t1_cycle1_grant", s_ig, 1);
        chk("t1_addr", s_addr, 32'h40);
        i_i_req = 0;
        for (int k = 0; k < BL; k++) begin
            i_mem_rdata_valid = 1; i_mem_rdata = 32'hA0 + k;
            step();
            chk("t1_beat", s_ir, 32'hA0 + k);
            chk("t1_done", s_id, (k == BL - 1));
            chk("t1_no_d", s_dv, 0);
        end
        i_mem_rdata_valid = 0;

        // Simultaneous requests: D write first, then I
        i_i_req = 1; i_i_addr = 32'h80;
        i_d_req = 1; i_d_we = 1; i_d_addr = 32'h100; i_d_wdata = 32'hDEAD;
        step();
        step();
        chk("t2_we", s_we, 1);
        chk("t2_addr", s_addr, 32'h100);
        chk("t2_wdata", s_wdata, 32'hDEAD);
        chk("t2_dgrant", s_dg, 1);
        chk("t2_ddone", s_dd, 1);
        i_d_req = 0;
        step();
        step();
        chk("t2_i_next", s_ig, 1);
        i_i_req = 0;
        beats(32'hB0);

        // Starvation: continuous D writes versus a waiting I
        i_i_req = 1; i_i_addr = 32'hC0; i_d_req = 1; i_d_we = 1; i_d_addr = 32'h200;
        nd = 0; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            step();
            if (s_dg) nd++;
            if (s_ig) got = 1;
        end
        chk("t3_i_granted", got, 1);
        chk("t3_d_wins_before_i", nd, 8);
        chk("t3_wait_cleared", m_wait, 0);
        i_i_req = 0; i_d_req = 0;
        beats(32'hC0);

        // Flush during D read burst after beat 1; I waiting
        i_d_req = 1; i_d_we = 0; i_d_addr = 32'h300;
        step();
        step();
        chk("t4_dgrant", s_dg, 1);
        i_d_req = 0; i_i_req = 1; i_i_addr = 32'h400;
        i_mem_rdata_valid = 1;
        i_mem_rdata = 32'hD0; step();
        i_mem_rdata = 32'hD1; step();
        chk("t4_beat1", s_dr, 32'hD1);
        i_flush = 1; i_mem_rdata = 32'hD2; step();
        chk("t4_beat2_suppressed", s_dv, 0);
        i_flush = 0; i_mem_rdata = 32'hD3; step();
        chk("t4_beat3_suppressed", s_dv, 0);
        chk("t4_no_done", s_dd, 0);
        i_mem_rdata_valid = 0;
        step();
        step();
        chk("t4_i_after_drain", s_ig, 1);
        i_i_req = 0;
        beats(32'hE0);

        // Flush while D in ISSUE, memory not ready
        i_d_req = 1; i_d_we = 0; i_d_addr = 32'h500; i_mem_req_ready = 0;
        step();
        i_flush = 1; step();
        chk("t5_dgrant", s_dg, 0);
        i_flush = 0; i_d_req = 0; step();
        chk("t5_valid_dropped", s_valid, 0);
        // Flush during an I-owned burst changes nothing
        i_i_req = 1; i_i_addr = 32'h600; i_mem_req_ready = 1;
        step(); step();
        i_i_req = 0; i_flush = 1;
        for (int k = 0; k < BL; k++) begin
            i_mem_rdata_valid = 1; i_mem_rdata = 32'hF0 + k;
            step();
            chk("t5_i_beat_valid", s_iv, 1);
            chk("t5_i_done", s_id, (k == BL - 1));
        end
        i_flush = 0; i_mem_rdata_valid = 0;

        // Reset mid-burst, then a fresh I read
        i_i_req = 1; i_i_addr = 32'h700;
        step(); step();
        i_i_req = 0; i_mem_rdata_valid = 1;
        step(); step();
        rst_n = 0; step();
        rst_n = 1; i_mem_rdata_valid = 1; step();
        chk("t6_iv_after_reset", s_iv, 0);
        chk("t6_valid_after_reset", s_valid, 0);
        i_mem_rdata_valid = 0;
        i_i_req = 1; i_i_addr = 32'h800;
        step(); step();
        chk("t6_regrant", s_ig, 1);
        i_i_req = 0;
        beats(32'h90);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom % 400) != 0;
            if (!i_i_req && $urandom % 3 == 0) begin i_i_req = 1; i_i_addr = $urandom; end
            if (!i_d_req && $urandom % 3 == 0) begin
                i_d_req = 1; i_d_we = $urandom % 2; i_d_addr = $urandom; i_d_wdata = $urandom;
            end
            i_flush = ($urandom % 12) == 0;
            i_mem_req_ready = $urandom % 2;
            i_mem_rdata_valid = ($urandom % 3) != 0;
            i_mem_rdata = $urandom;
            step();
            if (e_ig) i_i_req = 0;
            if (e_dg) i_d_req = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between two requesters:
  - I-side: instruction-cache refill, read bursts only.
  - D-side: the load-store queue / data cache, read bursts or single-beat writes.
- Sits between the cache controllers and the memory bus model.
- Sequences each transaction: arbitration, address issue, beat counting, completion.
- Supports D-side cancellation on pipeline flush.

Parameters:
ADDR_WIDTH, 32, address width of requests and memory port
DATA_WIDTH, 32, data beat width
BURST_LEN, 4, beats per read transaction (power of two, >=1)
MAX_WAIT, 8, cycles the I-side may lose arbitration before it is forced to win

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
i_flush  in  1  hazard-controller flush; cancels D-side work
i_i_req  in  1  I-side request, held until o_i_grant
i_i_addr  in  ADDR_WIDTH  I-side burst base address
o_i_grant  out  1  pulse: I request accepted by memory
o_i_rdata_valid  out  1  I-side read beat valid
o_i_rdata  out  DATA_WIDTH  I-side read beat
o_i_done  out  1  pulse with last I beat
i_d_req  in  1  D-side request, held until o_d_grant
i_d_we  in  1  D-side write (1) / read burst (0)
i_d_addr  in  ADDR_WIDTH  D-side address
i_d_wdata  in  DATA_WIDTH  D-side write data
o_d_grant  out  1  pulse: D request accepted by memory
o_d_rdata_valid  out  1  D-side read beat valid
o_d_rdata  out  DATA_WIDTH  D-side read beat
o_d_done  out  1  pulse: D write accepted, or last D read beat
o_mem_req_valid  out  1  request to memory
i_mem_req_ready  in  1  memory accepts request
o_mem_addr  out  ADDR_WIDTH  request address
o_mem_we  out  1  request is a write
o_mem_wdata  out  DATA_WIDTH  write data
i_mem_rdata_valid  in  1  memory read beat valid
i_mem_rdata  in  DATA_WIDTH  memory read beat

Behaviour:

Reset:
- State IDLE.
- Owner, beat counter and wait counter cleared.
- All outputs 0.
- Reset mid-transaction abandons the transaction. Memory-side cleanup is the bus model's concern.

States: IDLE, ISSUE, BURST, DRAIN.

IDLE:
- If any request is high, pick an owner, latch addr/we/wdata into registers, and go to ISSUE.
- Default priority is D over I.
- I wins when i_i_req is high and wait_cnt == MAX_WAIT.
- If only one requester is high, it wins.
- A D request during a cycle with i_flush=1 is ignored.

ISSUE:
- o_mem_req_valid=1, driven from the latched registers.
- Minimum latency: request at cycle N gives o_mem_req_valid at cycle N+1.
- On handshake (valid && ready), pulse the owner's grant in that cycle.
- D write handshake: o_d_done also pulses; next state IDLE.
- Read handshake: beat_cnt=0; next state BURST.

BURST:
- Each i_mem_rdata_valid beat is forwarded combinationally to the owner's rdata_valid/rdata in the same cycle.
- beat_cnt increments per beat, width $clog2(BURST_LEN)+1.
- On the beat where beat_cnt == BURST_LEN-1, the owner's done pulses; next state IDLE.
- The next arbitration therefore happens one cycle after done.

DRAIN:
- Same beat counting as BURST.
- Nothing is forwarded; no done.
- Returns to IDLE after the last beat.

Wait counter:
- Increments, saturating at MAX_WAIT, on each IDLE decision where i_i_req=1 and D wins.
- Cleared when I is granted.

Flush (affects D only; an I-owned transaction is unaffected):
- ISSUE, D owner, no handshake that cycle: drop o_mem_req_valid; next IDLE; no grant.
- ISSUE, D read, handshake same cycle: o_d_grant pulses; next state DRAIN.
- ISSUE, D write, handshake same cycle: completes normally (grant and done pulse). Accepted stores are never cancelled.
- BURST, D owner: the current beat is suppressed; go to DRAIN with beat_cnt preserved. If the suppressed beat was the last, go to IDLE instead.

Other rules:
- i_mem_rdata_valid while in IDLE or ISSUE is ignored.
- Grant, done and rdata_valid outputs are never high for the non-owner.

Test Plan:
- I-only read, BURST_LEN=4, mem ready immediately:
  - i_i_req at cycle 0 -> o_mem_req_valid at cycle 1, o_i_grant at cycle 1.
  - Beats 0xA0..0xA3 appear on o_i_rdata; o_i_done with 0xA3.
  - No D outputs asserted.
- Simultaneous i_i_req and i_d_req(we=1, addr=0x100, wdata=0xDEAD) -> D granted first:
  - o_mem_we=1, addr 0x100, wdata 0xDEAD.
  - o_d_done on the handshake.
  - I is granted at the following arbitration.
- Starvation: D requests continuously with MAX_WAIT=8 while I requests -> I wins on the 9th arbitration (wait_cnt=8); wait_cnt then returns to 0.
- Flush during D read BURST after beat 1 of 4 -> beats 2-3 consumed with o_d_rdata_valid=0, no o_d_done; I request pending during the flush is granted after the drain.
- Flush while D in ISSUE with i_mem_req_ready=0 -> o_mem_req_valid low next cycle, o_d_grant never pulses; same flush during an I-owned burst -> all I beats and o_i_done delivered unchanged.
- rst_n low mid-BURST -> all outputs 0 next cycle, state IDLE; a fresh I read afterwards completes with correct 4-beat sequence.
